pwm_wb_master: RTL

PWM_WB_MASTER -- requirements
Module: pwm_wb_master

---
 rtl/pwm_wb_pkg.sv | 29 ++
 rtl/pwm_wb_cmd_fifo.sv | 65 ++++++
 rtl/pwm_wb_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pwm_wb_pkg.sv
// -----------------------------------------------------------------------------
// pwm_wb_pkg
// Shared definitions for the PWM Wishbone command master:
//   - FSM state encoding (IDLE/BUS/DONE)
//   - PWM register offsets seen on the Wishbone side
//   - default FIFO depth and ack timeout
//   - command FIFO entry layout {we, adr, data}
// -----------------------------------------------------------------------------
package pwm_wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] REG_CTRL    = 16'h0000;
    localparam logic [15:0] REG_DIVISOR = 16'h0002;
    localparam logic [15:0] REG_PERIOD  = 16'h0004;
    localparam logic [15:0] REG_DC      = 16'h0006;

    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [15:0] data;
    } wb_cmd_t;

endpackage

// File: rtl/pwm_wb_cmd_fifo.sv
// -----------------------------------------------------------------------------
// pwm_wb_cmd_fifo
// Command FIFO, 33-bit entries {we, adr, data}, DEPTH entries.
// Ports:
//   i_wb_clk, i_wb_rst   clock / async active-high reset
//   push, push_data      write request (ignored while full)
//   pop                  read request (ignored while empty)
//   head                 entry at the read pointer
//   full, empty          registered status flags
//   nonempty             live pointer compare (for status reporting)
// -----------------------------------------------------------------------------
module pwm_wb_cmd_fifo
    import pwm_wb_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        push,
    input  logic [32:0] push_data,
    input  logic        pop,
    output logic [32:0] head,
    output logic        full,
    output logic        empty,
    output logic        nonempty
);

    localparam int AW = $clog2(DEPTH);

    logic [32:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic        do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};

    assign head     = mem[rd_ptr[AW-1:0]];
    assign nonempty = (wr_ptr != rd_ptr);

    // full tracks the next pointers so a push can never overrun.
    // empty is the compare of the current pointers, i.e. one edge behind:
    // that is safe because the only reader pops at most once per
    // IDLE->BUS->DONE round (>= 3 edges), and it gives the command a
    // two-edge accept-to-bus latency.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            empty  <= (wr_ptr == rd_ptr);
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pwm_wb_master.sv
// -----------------------------------------------------------------------------
// pwm_wb_master
// Queues register read/write commands and plays them out one at a time as
// Wishbone classic cycles toward the PWM slave, returning one response each.
// Ports:
//   i_wb_clk, i_wb_rst                       clock / async active-high reset
//   i_cmd_valid, o_cmd_ready, i_cmd_we,
//   i_cmd_adr[15:0], i_cmd_data[15:0]        command input (we: 1 write, 0 read)
//   o_wb_cyc, o_wb_stb, o_wb_we,
//   o_wb_adr[15:0], o_wb_data[15:0]          Wishbone master outputs
//   i_wb_ack, i_wb_data[15:0]                slave ack / read data
//   o_rsp_valid, o_rsp_data[15:0], o_rsp_err one-cycle response
//   o_busy                                   FSM active or commands queued
// Build option:
//   PWM_WB_MASTER_TIMEOUT_EN  abort a bus cycle after TIMEOUT_CYCLES without
//                             ack (o_rsp_err=1); otherwise BUS waits forever.
// -----------------------------------------------------------------------------
module pwm_wb_master
    import pwm_wb_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [15:0] i_cmd_adr,
    input  logic [15:0] i_cmd_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [15:0] o_wb_adr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [15:0] i_wb_data,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_busy
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  state;
    logic [32:0] fifo_head;
    wb_cmd_t     head;
    logic        fifo_full, fifo_empty, fifo_nonempty;
    logic        pop;
    logic        to_hit;

    assign head        = wb_cmd_t'(fifo_head);
    assign o_cmd_ready = !fifo_full;
    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign o_busy      = (state != ST_IDLE) || fifo_nonempty;

    pwm_wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_wb_clk  (i_wb_clk),
        .i_wb_rst  (i_wb_rst),
        .push      (i_cmd_valid),
        .push_data ({i_cmd_we, i_cmd_adr, i_cmd_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .nonempty  (fifo_nonempty)
    );

`ifdef PWM_WB_MASTER_TIMEOUT_EN
    // Counts completed BUS cycles; hits on the edge ending the
    // TIMEOUT_CYCLES-th one.
    logic [7:0] to_cnt;

    assign to_hit = (state == ST_BUS) && (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst)                         to_cnt <= 8'd0;
        else if (pop)                         to_cnt <= 8'd0;
        else if (state == ST_BUS && !i_wb_ack) to_cnt <= to_cnt + 8'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state       <= ST_IDLE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= 16'h0000;
            o_wb_data   <= 16'h0000;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_BUS;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= head.we;
                        o_wb_adr <= head.adr;
                        // reads leave the write-data lines untouched
                        if (head.we) o_wb_data <= head.data;
                    end
                end
                ST_BUS: begin
                    // ack takes priority over a simultaneous timeout
                    if (i_wb_ack) begin
                        state       <= ST_DONE;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b0;
                        o_rsp_data  <= o_wb_we ? 16'h0000 : i_wb_data;
                    end else if (to_hit) begin
                        state       <= ST_DONE;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_data  <= 16'h0000;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_rsp_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
